// File: rtl/alu_if.sv
// Operand/result bundle for the registered ALU; the master drives operands, the slave returns the result and flags.
interface alu_if;
  logic [3:0] A;
  logic [1:0] B;
  logic [1:0] sel;
  logic [3:0] Y;
  logic       Z;
  logic       N;
  logic       C;
  logic       V;

  modport master (output A, B, sel, input Y, Z, N, C, V);
  modport slave  (input A, B, sel, output Y, Z, N, C, V);
endinterface

// File: rtl/alu.sv
// Registered 4-bit ALU: MUL/SUB/AND/XOR of A with zero-extended B, plus Z/N/C/V flags.
// Latency one cycle; no backpressure, a new op is accepted on every rising clk.
module alu (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  logic [3:0] a;
  logic [3:0] bx;
  logic [1:0] op;

  assign a  = bus.A;
  assign bx = {2'b00, bus.B};
  assign op = bus.sel;

  // Multiplier array: two partial-product rows, second row shifted by one and
  // summed with a ripple of full adders into a 6-bit product.
  logic [3:0] pp0;
  logic [3:0] pp1;
  logic [3:0] row_a;
  logic [4:0] mul_carry;
  logic [5:0] prod;

  assign pp0          = a & {4{bx[0]}};
  assign pp1          = a & {4{bx[1]}};
  assign row_a        = {1'b0, pp0[3:1]};
  assign mul_carry[0] = 1'b0;
  assign prod[0]      = pp0[0];

  for (genvar i = 0; i < 4; i++) begin : g_mul
    assign prod[i+1]      = row_a[i] ^ pp1[i] ^ mul_carry[i];
    assign mul_carry[i+1] = (row_a[i] & pp1[i]) | (mul_carry[i] & (row_a[i] ^ pp1[i]));
  end

  assign prod[5] = mul_carry[4];

  // Ripple-borrow subtractor; the final borrow is the A < B indication.
  logic [3:0] diff;
  logic [4:0] borrow;

  assign borrow[0] = 1'b0;

  for (genvar j = 0; j < 4; j++) begin : g_sub
    assign diff[j]     = a[j] ^ bx[j] ^ borrow[j];
    assign borrow[j+1] = (~a[j] & bx[j]) | (~(a[j] ^ bx[j]) & borrow[j]);
  end

  logic [3:0] and_res;
  logic [3:0] xor_res;

  assign and_res = a & bx;
  assign xor_res = a ^ bx;

  logic [3:0] y_nxt;
  logic       c_nxt;
  logic       v_nxt;
  logic       z_nxt;
  logic       n_nxt;

  always_comb begin
    y_nxt = 4'b0000;
    c_nxt = 1'b0;
    v_nxt = 1'b0;
    case (op)
      2'b00: begin
        y_nxt = prod[3:0];
        c_nxt = prod[5] | prod[4];
      end
      2'b01: begin
        y_nxt = diff;
        c_nxt = borrow[4];
        // Only a negative A can overflow when subtracting a non-negative value.
        v_nxt = a[3] & ~diff[3];
      end
      2'b10:   y_nxt = and_res;
      default: y_nxt = xor_res;
    endcase
  end

  assign z_nxt = (y_nxt == 4'b0000);
  assign n_nxt = y_nxt[3];

  logic [3:0] y_q;
  logic       z_q;
  logic       n_q;
  logic       c_q;
  logic       v_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= 4'b0000;
      z_q <= 1'b1;
      n_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      y_q <= y_nxt;
      z_q <= z_nxt;
      n_q <= n_nxt;
      c_q <= c_nxt;
      v_q <= v_nxt;
    end
  end

  assign bus.Y = y_q;
  assign bus.Z = z_q;
  assign bus.N = n_q;
  assign bus.C = c_q;
  assign bus.V = v_q;

endmodule

// File: tb/tb_alu.sv
// Bench for the registered ALU: directed vectors, latency/reset checks and random ops against an arithmetic model.
module tb_alu;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  alu_if bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {Y, Z, N, C, V}
  function automatic logic [7:0] observed();
    return {bus.Y, bus.Z, bus.N, bus.C, bus.V};
  endfunction

  function automatic logic [7:0] model(input int a, input int b, input int s);
    int         r;
    logic [3:0] y;
    logic       c;
    logic       v;
    c = 1'b0;
    v = 1'b0;
    case (s)
      0: begin
        r = a * b;
        y = r[3:0];
        c = (r > 15);
      end
      1: begin
        r = a - b;
        if (r < 0) r = r + 16;
        y = r[3:0];
        c = (a < b);
        v = (a >= 8) && (y < 8);
      end
      2: begin
        r = a & b;
        y = r[3:0];
      end
      default: begin
        r = a ^ b;
        y = r[3:0];
      end
    endcase
    return {y, (y == 4'd0), y[3], c, v};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got YZNCV=%b_%b expected %b_%b", tag, got[7:4], got[3:0], exp[7:4], exp[3:0]);
    end
  endtask

  // Drive between edges, then sample just after the capturing edge.
  task automatic apply(input int a, input int b, input int s);
    @(negedge clk);
    bus.A   = 4'(a);
    bus.B   = 2'(b);
    bus.sel = 2'(s);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] prev;
  logic [7:0] dir_exp [0:7];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.A   = 4'd0;
    bus.B   = 2'd0;
    bus.sel = 2'd0;
    rst     = 1'b1;
    #2;
    chk("reset_async", observed(), 8'b0000_1000);
    @(posedge clk);
    #1;
    chk("reset_held", observed(), 8'b0000_1000);
    @(negedge clk);
    rst = 1'b0;

    dir_exp = '{8'h50, 8'h40, 8'h10, 8'h40, 8'hD6, 8'hC4, 8'h30, 8'hC4};
    for (int s = 0; s < 4; s++) begin
      apply(5, 1, s);
      chk($sformatf("a5_b1_sel%0d", s), observed(), dir_exp[s]);
    end
    for (int s = 0; s < 4; s++) begin
      apply(15, 3, s);
      chk($sformatf("a15_b3_sel%0d", s), observed(), dir_exp[4+s]);
    end
    for (int s = 0; s < 4; s++) begin
      apply(0, 0, s);
      chk($sformatf("zero_sel%0d", s), observed(), 8'b0000_1000);
    end
    apply(8, 1, 1);
    chk("sub_overflow", observed(), 8'h71);
    apply(1, 2, 1);
    chk("sub_borrow", observed(), 8'hF6);
    apply(0, 3, 1);
    chk("sub_zero_wrap", observed(), model(0, 3, 1));
    apply(9, 0, 0);
    chk("mul_b0", observed(), 8'b0000_1000);

    // Operand changes between edges must not reach the outputs early.
    apply(6, 2, 0);
    prev = observed();
    chk("latency_base", prev, model(6, 2, 0));
    @(negedge clk);
    bus.sel = 2'd3;
    bus.A   = 4'd9;
    #2;
    chk("latency_hold", observed(), prev);
    @(posedge clk);
    #1;
    chk("latency_update", observed(), model(9, 2, 3));

    // Reset asserted mid-cycle overrides immediately and holds across edges.
    apply(15, 3, 0);
    @(negedge clk);
    bus.A   = 4'd7;
    bus.B   = 2'd3;
    bus.sel = 2'd1;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_immediate", observed(), 8'b0000_1000);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_mid_hold%0d", k), observed(), 8'b0000_1000);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_no_edge", observed(), 8'b0000_1000);
    @(posedge clk);
    #1;
    chk("rst_first_op", observed(), model(7, 3, 1));

    for (int t = 0; t < 300; t++) begin
      int a;
      int b;
      int s;
      a = int'($urandom_range(15, 0));
      b = int'($urandom_range(3, 0));
      s = int'($urandom_range(3, 0));
      apply(a, b, s);
      chk($sformatf("rand%0d_a%0d_b%0d_s%0d", t, a, b, s), observed(), model(a, b, s));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
